// File: rtl/store_buffer.sv
// Posted-write FIFO between the store path and the data memory write port.
// Drains one entry per free memory cycle and flags loads that hit a pending store.
`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_memop,
  output logic             st_misalign,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  input  logic             mem_busy,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic [1:0]       mem_memop,
  input  logic             sync_req,
  output logic             sync_done,
  output logic [PTR_W:0]   count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_SYNC = 1'b1;

  logic [31:0]      addr_reg  [DEPTH];
  logic [31:0]      data_reg  [DEPTH];
  logic [1:0]       memop_reg [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [0:0]       state_reg;
  logic             misalign_reg;

  logic             st_aligned;
  logic             enq;
  logic             deq;
  logic             empty;
  logic [DEPTH-1:0] hit_vec;
  logic             unused_ld_bits;

  // Undefined size 2'b11 falls into the default arm and is checked as a word.
  always_comb begin
    st_aligned = 1'b1;
    case (st_memop)
      `MEM_BYTE: st_aligned = 1'b1;
      `MEM_HALF: st_aligned = ~st_addr[0];
      default:   st_aligned = (st_addr[1:0] == 2'b00);
    endcase
  end

  assign empty     = (count_reg == '0);
  assign st_ready  = (count_reg < (PTR_W+1)'(DEPTH)) && (state_reg == ST_RUN) && !sync_req;
  assign enq       = st_valid && st_ready && st_aligned;
  assign deq       = !empty && !mem_busy;
  assign mem_wr    = deq;
  assign mem_addr  = empty ? 32'd0 : addr_reg[head_reg];
  assign mem_din   = empty ? 32'd0 : data_reg[head_reg];
  assign mem_memop = empty ? 2'd0  : memop_reg[head_reg];
  assign sync_done = sync_req && empty;
  assign count     = count_reg;
  assign st_misalign = misalign_reg;
  assign unused_ld_bits = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_reg[tail_reg]  <= st_addr;
      data_reg[tail_reg]  <= st_data;
      memop_reg[tail_reg] <= st_memop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      state_reg    <= ST_RUN;
      misalign_reg <= 1'b0;
    end else begin
      if (enq)
        tail_reg <= tail_reg + PTR_W'(1);
      if (deq)
        head_reg <= head_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (st_valid && st_ready && !st_aligned)
        misalign_reg <= 1'b1;
      state_reg <= sync_req ? ST_SYNC : ST_RUN;
    end
  end

  // An entry slot is live when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PTR_W-1:0] off;
    assign off         = PTR_W'(gi) - head_reg;
    assign hit_vec[gi] = ({1'b0, off} < count_reg) && (addr_reg[gi][31:2] == ld_addr[31:2]);
  end

  assign ld_hit = ld_valid && (|hit_vec);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: inputs driven 1 time unit after posedge,
// outputs checked at the following negedge.
`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_memop;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        mem_busy;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_memop;
  logic        sync_req;
  logic        sync_done;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_memop(st_memop), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .mem_busy(mem_busy), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_memop(mem_memop),
    .sync_req(sync_req), .sync_done(sync_done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    st_valid = 1'b1; st_addr = a; st_data = d; st_memop = op;
    adv();
    st_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_memop = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_busy = 1'b0; sync_req = 1'b0;
    adv(); adv();
    rst = 1'b0;

    // Reset / idle state
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    chk("rst_sync_done", 32'(sync_done), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Single word store, one-cycle latency to mem_wr
    adv();
    put(32'h0000_2004, 32'hDEADBEEF, `MEM_WORD);
    @(negedge clk);
    chk("one_mem_wr", 32'(mem_wr), 32'd1);
    chk("one_mem_addr", mem_addr, 32'h0000_2004);
    chk("one_mem_din", mem_din, 32'hDEADBEEF);
    chk("one_memop", 32'(mem_memop), 32'(`MEM_WORD));
    chk("one_count", 32'(count), 32'd1);
    adv();
    @(negedge clk);
    chk("one_drained", 32'(count), 32'd0);
    chk("one_wr_off", 32'(mem_wr), 32'd0);

    // Fill while memory is busy, reject fifth, then drain in order
    adv();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      put(32'h2000 + 32'(4 * i), 32'h1000 + 32'(i), `MEM_WORD);
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_no_wr", 32'(mem_wr), 32'd0);
    adv();
    put(32'h2010, 32'h5555, `MEM_WORD);
    @(negedge clk);
    chk("fifth_reject", 32'(count), 32'd4);
    adv();
    mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_wr", 32'(mem_wr), 32'd1);
      chk("drain_addr", mem_addr, 32'h2000 + 32'(4 * i));
      chk("drain_din", mem_din, 32'h1000 + 32'(i));
      chk("drain_ready", 32'(st_ready), (i == 0) ? 32'd0 : 32'd1);
      adv();
    end
    @(negedge clk);
    chk("drain_empty", 32'(count), 32'd0);

    // Load hazard detection on a pending byte store
    adv();
    mem_busy = 1'b1;
    put(32'h2003, 32'h0000_00AB, `MEM_BYTE);
    ld_valid = 1'b1; ld_addr = 32'h2000;
    @(negedge clk);
    chk("hit_same_word", 32'(ld_hit), 32'd1);
    adv();
    ld_addr = 32'h2004;
    @(negedge clk);
    chk("hit_next_word", 32'(ld_hit), 32'd0);
    adv();
    ld_addr = 32'h2000; mem_busy = 1'b0;
    @(negedge clk);
    chk("hit_head_wr", 32'(ld_hit), 32'd1);
    chk("byte_wr", 32'(mem_wr), 32'd1);
    chk("byte_memop", 32'(mem_memop), 32'(`MEM_BYTE));
    chk("byte_din", mem_din, 32'h0000_00AB);
    adv();
    @(negedge clk);
    chk("hit_after", 32'(ld_hit), 32'd0);
    adv();
    st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'h77; st_memop = `MEM_WORD;
    @(negedge clk);
    chk("hit_enq_same", 32'(ld_hit), 32'd0);
    adv();
    st_valid = 1'b0; ld_valid = 1'b0;
    adv();
    @(negedge clk);
    chk("enq_drained", 32'(count), 32'd0);

    // Misaligned stores are dropped and flagged; memop 2'b11 treated as word
    adv();
    put(32'h2001, 32'h1, `MEM_HALF);
    put(32'h2002, 32'h2, `MEM_WORD);
    put(32'h2002, 32'h3, 2'b11);
    @(negedge clk);
    chk("mis_count", 32'(count), 32'd0);
    chk("mis_flag", 32'(st_misalign), 32'd1);
    adv();
    put(32'h3008, 32'h4, 2'b11);
    @(negedge clk);
    chk("m11_memop", 32'(mem_memop), 32'd3);
    chk("m11_addr", mem_addr, 32'h3008);
    adv();
    @(negedge clk);
    chk("mis_sticky", 32'(st_misalign), 32'd1);
    chk("m11_drained", 32'(count), 32'd0);

    // Sync: stop accepting, drain, report done
    adv();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      put(32'h4000 + 32'(4 * i), 32'(i), `MEM_WORD);
    sync_req = 1'b1;
    @(negedge clk);
    chk("sync_ready", 32'(st_ready), 32'd0);
    chk("sync_busy_dn", 32'(sync_done), 32'd0);
    adv();
    mem_busy = 1'b0;
    st_valid = 1'b1; st_addr = 32'h5000; st_memop = `MEM_WORD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sync_pending", 32'(sync_done), 32'd0);
      chk("sync_cnt", 32'(count), 32'(3 - i));
      adv();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("sync_done", 32'(sync_done), 32'd1);
    chk("sync_empty", 32'(count), 32'd0);
    adv();
    @(negedge clk);
    chk("sync_hold", 32'(sync_done), 32'd1);
    adv();
    sync_req = 1'b0;
    adv();
    @(negedge clk);
    chk("unsync_ready", 32'(st_ready), 32'd1);
    chk("unsync_done", 32'(sync_done), 32'd0);

    // Reset discards pending entries without writing them
    adv();
    mem_busy = 1'b1;
    put(32'h6000, 32'hA, `MEM_WORD);
    put(32'h6004, 32'hB, `MEM_WORD);
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd2);
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_wr", 32'(mem_wr), 32'd0);
    chk("post_rst_mis", 32'(st_misalign), 32'd0);
    chk("post_rst_ready", 32'(st_ready), 32'd1);
    adv();
    @(negedge clk);
    chk("post_rst_wr2", 32'(mem_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU's memory-stage store path and the data memory write port.
- Accepts stores (address, data, size) with a valid/ready handshake and holds up to DEPTH entries in FIFO order.
- Drains one entry per cycle into the data memory whenever the port is not claimed by a load.
- Detects loads that hit a pending store so the core can stall, and provides a sync (drain-to-empty) request for fences and syscalls.

Parameters:
DEPTH, 4, number of buffered stores (power of two, minimum 2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
st_valid  input  1  store request from CPU
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  32  store byte address
st_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
st_memop  input  2  `MEM_BYTE / `MEM_HALF / `MEM_WORD
st_misalign  output  1  sticky: a misaligned store was rejected
ld_valid  input  1  load in progress this cycle
ld_addr  input  32  load byte address
ld_hit  output  1  load word-address matches a pending entry; core must stall
mem_busy  input  1  data memory port used by a load this cycle
mem_wr  output  1  write strobe to data memory (DMWr)
mem_addr  output  32  head entry address
mem_din  output  32  head entry data
mem_memop  output  2  head entry size
sync_req  input  1  request: stop accepting, drain to empty
sync_done  output  1  buffer empty while sync_req is high
count  output  PTR_W+1  number of valid entries

Behaviour:
- Storage: DEPTH entries of {addr[31:0], data[31:0], memop[1:0]}, with head pointer, tail pointer and count registers. Pointers wrap modulo DEPTH.
- Reset (rst=1 at posedge): head=0, tail=0, count=0, state=RUN, st_misalign=0. Pending entries are discarded with no memory write. All derived outputs settle to their empty-buffer values in the same cycle:
  - mem_wr=0, st_ready=1, ld_hit=0, sync_done=0.
  - mem_addr, mem_din and mem_memop are don't-care but drive 0 when the buffer is empty.
- FSM has two states, RUN and SYNC:
  - RUN -> SYNC when sync_req=1.
  - SYNC -> RUN when sync_req=0.
  - SYNC holds while sync_req=1.
- st_ready is combinational: (count < DEPTH) and state==RUN and sync_req==0. There is no same-cycle bypass, so a full buffer that pops in a cycle does not also accept in that cycle.
- Enqueue: when st_valid and st_ready and the store is aligned, the entry is written at tail on posedge; tail+1, count+1.
- Alignment rule:
  - `MEM_HALF requires addr[0]=0.
  - `MEM_WORD requires addr[1:0]=0.
  - `MEM_BYTE is always aligned.
  - A misaligned store is not enqueued; st_misalign is set (sticky until rst).
- Dequeue:
  - mem_wr = (count != 0) and !mem_busy, combinational.
  - mem_addr, mem_din and mem_memop show the head entry.
  - The memory captures the write on the following negedge; on the next posedge, head+1 and count-1.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Latency: a store accepted at posedge N is first eligible for mem_wr in cycle N+1 (empty buffer, mem_busy=0). Memory contents are updated at the negedge of cycle N+1.
- ld_hit is combinational. It is asserted when ld_valid=1 and any valid entry has addr[31:2]==ld_addr[31:2], regardless of size or byte lane.
  - The head entry being written this cycle still counts as a hit.
  - The entry being enqueued in the same cycle is not compared.
- sync_done = sync_req and count==0, combinational. It stays high while sync_req is held and the buffer remains empty.
- mem_busy held high stalls draining indefinitely. No entries are lost, and ld_hit remains correct.
- st_memop value 2'b11 (undefined) is treated as `MEM_WORD for alignment and stored unchanged.

Test Plan:
- rst for 2 cycles, then idle: count=0, mem_wr=0, st_ready=1, ld_hit=0, st_misalign=0.
- Single store 0x0000_2004 / 0xDEADBEEF / `MEM_WORD accepted at posedge N, mem_busy=0: mem_wr=1 in cycle N+1 with mem_addr=0x0000_2004; count returns to 0 at posedge N+2.
- mem_busy=1, four word stores to 0x2000, 0x2004, 0x2008, 0x200C:
  - Expected: count=4 and st_ready=0; a fifth st_valid is not accepted.
  - Then release mem_busy: four consecutive mem_wr cycles in address order; st_ready=1 again once count<4.
- Pending byte store at 0x2003, then ld_valid with ld_addr=0x2000: ld_hit=1. With ld_addr=0x2004: ld_hit=0. After the entry drains, ld_addr=0x2000 gives ld_hit=0.
- `MEM_HALF store to 0x2001 and `MEM_WORD store to 0x2002: neither is enqueued (count stays 0); st_misalign=1 and stays 1 until rst.
- Three entries buffered, sync_req=1:
  - Expected: st_ready=0 immediately; sync_done=0 until count=0, then 1.
  - Drop sync_req: st_ready=1.
  - Assert rst with 2 entries pending: count=0 next cycle, and no mem_wr for the discarded entries.
